v2f_seq_udiv32: RTL and testbench
=================================

V2F_SEQ_UDIV32 -- requirements
Module: v2f_seq_udiv32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is legal.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, quotient bits retired per CALC cycle; legal values are 1 and 2.
REQ-003 SHALL have port pos_clk, input, 1, clock, rising-edge active.
REQ-004 SHALL have port pos_arst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand request.
REQ-006 SHALL have port in_ready, output, 1, operands accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have port dividend, input, WIDTH, unsigned numerator.
REQ-008 SHALL have port divisor, input, WIDTH, unsigned denominator.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high at a rising edge.
REQ-011 SHALL have port quotient, output, WIDTH, unsigned quotient.
REQ-012 SHALL have port remainder, output, WIDTH, unsigned remainder.
REQ-013 SHALL have port div_by_zero, output, 1, set with a result whose divisor was 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE, where in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL, on acceptance in IDLE, register both operands, clear the partial remainder, set the iteration counter to WIDTH/BITS_PER_CYCLE, and enter CALC, or enter DONE directly if divisor==0.
REQ-016 SHALL, in CALC, perform restoring division with one shift/compare/subtract step per retired bit, MSB first, decrementing the counter once per cycle.
REQ-017 SHALL treat a carry-out of the shifted partial remainder (bit WIDTH set) as remainder >= divisor and subtract unconditionally.
REQ-018 SHALL enter DONE on the edge that retires the last bit, so out_valid rises exactly WIDTH/BITS_PER_CYCLE+1 edges after the acceptance edge (33 for the defaults).
REQ-019 SHALL, when divisor==0, raise out_valid one edge after acceptance with quotient = all ones, remainder = dividend, and div_by_zero=1.
REQ-020 SHALL clear div_by_zero for every nonzero-divisor result.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid && out_ready, return to IDLE, with in_ready rising on that same edge and no same-cycle result-to-accept bypass.
REQ-023 SHALL ignore in_valid in CALC and DONE, and ignore out_ready in IDLE and CALC.
REQ-024 SHALL produce results equal to the unsigned operators / and % for all nonzero divisors, including operands with bit 31 set.

Reset
REQ-025 SHALL, while pos_arst=1, force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-026 SHALL, on pos_arst asserted mid-CALC or in DONE, discard the operation with no result emitted, and accept a new operation on the first edge after deassertion.

Structure
REQ-027 SHALL take from the shared package v2f_pkg the state enum type v2f_div_state_t, the constant V2F_SIGN_BIAS = 32'h80000000, and the constant V2F_WORD = 32.
REQ-028 SHALL perform every unsigned magnitude comparison by adding V2F_SIGN_BIAS to both operands and applying a signed compare, keeping all arithmetic within the 32-bit signed combinator model.
REQ-029 SHALL place that comparison in one sub-module, v2f_ucmp32 (inputs a, b; output a_ge_b), instantiated once per retired bit.

Verification
REQ-030 SHALL check: dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0, out_valid exactly 33 edges after acceptance.
REQ-031 SHALL check: dividend=0x80000000, divisor=0xFFFFFFFF -> quotient=0, remainder=0x80000000; and dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-032 SHALL check: dividend=5, divisor=0 -> out_valid one edge after acceptance, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-033 SHALL check backpressure: with out_ready=0 for 10 cycles in DONE, outputs are held, in_ready=0, and in_valid pulses are ignored; out_ready=1 then gives IDLE next edge and exactly one result.
REQ-034 SHALL check reset mid-operation: pos_arst pulsed at CALC cycle 16 of 1000/3 -> out_valid never rises for that operation; a following 9/4 gives quotient=2, remainder=1.
REQ-035 SHALL check randomized back-to-back operands with BITS_PER_CYCLE=2 against the reference / and %, with latency 17 edges.

Source files
------------

// File: rtl/v2f_pkg.sv
// Shared definitions for the v2f arithmetic blocks.
//   v2f_div_state_t : control states of the sequential divider
//   V2F_WORD        : native datapath word width
//   V2F_SIGN_BIAS   : offset that maps unsigned values onto the signed range,
//                     so unsigned ordering can be tested with a signed compare
package v2f_pkg;

    localparam int          V2F_WORD      = 32;
    localparam logic [31:0] V2F_SIGN_BIAS = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } v2f_div_state_t;

endpackage

// File: rtl/v2f_ucmp32.sv
// Unsigned 32-bit magnitude compare built from a signed comparator.
// Adding the sign bias flips the MSB of both operands, which turns unsigned
// ordering into two's-complement ordering.
//   a, b   : unsigned operands
//   a_ge_b : 1 when a >= b (unsigned)
module v2f_ucmp32
    import v2f_pkg::*;
(
    input  logic [V2F_WORD-1:0] a,
    input  logic [V2F_WORD-1:0] b,
    output logic                a_ge_b
);

    logic signed [V2F_WORD-1:0] a_biased;
    logic signed [V2F_WORD-1:0] b_biased;

    assign a_biased = a + V2F_SIGN_BIAS;
    assign b_biased = b + V2F_SIGN_BIAS;
    assign a_ge_b   = (a_biased >= b_biased);

endmodule

// File: rtl/v2f_seq_udiv32.sv
// Sequential unsigned 32-bit restoring divider with valid/ready handshakes.
//   pos_clk, pos_arst     : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only while idle)
//   dividend, divisor     : unsigned operands
//   out_valid / out_ready : result handshake (valid only while done)
//   quotient, remainder   : unsigned result, held until consumed
//   div_by_zero           : result came from a zero divisor
//                           (quotient all ones, remainder = dividend)
// BITS_PER_CYCLE (1 or 2) quotient bits are retired per CALC cycle; WIDTH must
// be 32.
module v2f_seq_udiv32
    import v2f_pkg::*;
#(
    parameter int WIDTH          = V2F_WORD,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             pos_clk,
    input  logic             pos_arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(WIDTH + 1);

    v2f_div_state_t   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg;   // partial remainder
    logic [WIDTH-1:0] dvd_reg;   // dividend shifts out MSB-first, quotient shifts in LSB
    logic [WIDTH-1:0] dsr_reg;   // latched divisor
    logic             dz_reg;
    logic             accept;
    logic             divisor_zero;

    // Unrolled restoring steps: stage 0 is the registered state, stage
    // BITS_PER_CYCLE is what gets written back at the end of a CALC cycle.
    logic [WIDTH-1:0] stage_rem [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] stage_dvd [0:BITS_PER_CYCLE];

    assign stage_rem[0] = rem_reg;
    assign stage_dvd[0] = dvd_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [WIDTH:0] shifted;
            logic           cmp_ge;
            logic           take;

            assign shifted = {stage_rem[gi], stage_dvd[gi][WIDTH-1]};

            v2f_ucmp32 u_cmp (
                .a      (shifted[WIDTH-1:0]),
                .b      (dsr_reg),
                .a_ge_b (cmp_ge)
            );

            // A carry out of the shift means the true value already exceeds
            // any 32-bit divisor; the modulo-2^32 subtraction is still exact
            // because the difference is smaller than the divisor.
            assign take = shifted[WIDTH] | cmp_ge;

            assign stage_rem[gi+1] = take ? (shifted[WIDTH-1:0] - dsr_reg)
                                          : shifted[WIDTH-1:0];
            assign stage_dvd[gi+1] = {stage_dvd[gi][WIDTH-2:0], take};
        end
    endgenerate

    assign divisor_zero = (divisor == '0);
    assign accept       = in_valid && in_ready;

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            cnt_reg <= '0;
            rem_reg <= '0;
            dvd_reg <= '0;
            dsr_reg <= '0;
            dz_reg  <= 1'b0;
        end else if (accept) begin
            dsr_reg <= divisor;
            dz_reg  <= divisor_zero;
            if (divisor_zero) begin
                dvd_reg <= '1;
                rem_reg <= dividend;
                cnt_reg <= '0;
            end else begin
                dvd_reg <= dividend;
                rem_reg <= '0;
                cnt_reg <= CNT_W'(STEPS);
            end
        end else if (state_reg == CALC) begin
            rem_reg <= stage_rem[BITS_PER_CYCLE];
            dvd_reg <= stage_dvd[BITS_PER_CYCLE];
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign quotient    = dvd_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_v2f_seq_udiv32.sv
module tb_v2f_seq_udiv32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        arst;
    logic        sel;        // 0: BITS_PER_CYCLE=1 instance, 1: BITS_PER_CYCLE=2 instance
    logic        in_valid;
    logic        out_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, dz1;
    logic [31:0] quo1, rem1;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, dz2;
    logic [31:0] quo2, rem2;

    logic        rdy, ov, dz;
    logic [31:0] quo, rmd;

    int   vectors     = 0;
    int   miscompares = 0;
    int   hs1         = 0;
    int   hs2         = 0;
    exp_t sb[$];

    assign in_valid1  = in_valid && !sel;
    assign in_valid2  = in_valid && sel;
    assign out_ready1 = out_ready && !sel;
    assign out_ready2 = out_ready && sel;
    assign rdy = sel ? in_ready2  : in_ready1;
    assign ov  = sel ? out_valid2 : out_valid1;
    assign quo = sel ? quo2       : quo1;
    assign rmd = sel ? rem2       : rem1;
    assign dz  = sel ? dz2        : dz1;

    v2f_seq_udiv32 #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .pos_clk     (clk),
        .pos_arst    (arst),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid1),
        .out_ready   (out_ready1),
        .quotient    (quo1),
        .remainder   (rem1),
        .div_by_zero (dz1)
    );

    v2f_seq_udiv32 #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut2 (
        .pos_clk     (clk),
        .pos_arst    (arst),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .quotient    (quo2),
        .remainder   (rem2),
        .div_by_zero (dz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid1 && out_ready1) hs1 <= hs1 + 1;
        if (out_valid2 && out_ready2) hs2 <= hs2 + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Present operands and complete the acceptance edge; leaves time at edge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!rdy && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_ready_before_send", rdy, 1'b1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b));
        #1;
        in_valid = 1'b0;
    endtask

    // Edges counted with the acceptance edge as edge 1.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 1;
        while (!ov && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic consume(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_quotient"}, quo, e.q);
            check({tag, "_remainder"}, rmd, e.r);
            check({tag, "_div_by_zero"}, dz, e.dz);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, ov, 1'b0);
        check({tag, "_in_ready_after"}, rdy, 1'b1);
        $display("op %s done: q=%h r=%h dz=%0d", tag, quo, rmd, dz);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat);
        send(a, b);
        wait_result({tag, "_latency"}, exp_lat);
        consume(tag);
    endtask

    initial begin
        exp_t held;
        int   hs_snap;
        logic [31:0] ra, rb;

        arst      = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        #2;
        check("rst_in_ready", in_ready1, 1'b1);
        check("rst_out_valid", out_valid1, 1'b0);
        check("rst_quotient", quo1, 32'd0);
        check("rst_remainder", rem1, 32'd0);
        check("rst_div_by_zero", dz1, 1'b0);
        check("rst_out_valid_bpc2", out_valid2, 1'b0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Directed single-bit-per-cycle operations
        run_op("d100_7", 32'd100, 32'd7, 33);
        run_op("d8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_op("dffff_1", 32'hFFFF_FFFF, 32'd1, 33);
        run_op("d5_0", 32'd5, 32'd0, 1);
        run_op("d7_100", 32'd7, 32'd100, 33);
        run_op("dffff_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("dfffe_8000", 32'hFFFF_FFFE, 32'h8000_0000, 33);
        run_op("dffff_7fff", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);

        // Backpressure: result held for 10 cycles, in_valid pulses ignored
        send(32'd12345678, 32'd1234);
        wait_result("bp_latency", 33);
        held = sb[0];
        for (int i = 0; i < 10; i++) begin
            dividend = $urandom;
            divisor  = 32'd3;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("bp_hold_quotient", quo, held.q);
            check("bp_hold_remainder", rmd, held.r);
            check("bp_hold_div_by_zero", dz, held.dz);
            check("bp_out_valid", ov, 1'b1);
            check("bp_in_ready", rdy, 1'b0);
        end
        in_valid = 1'b0;
        hs_snap = hs1;
        consume("bp");
        check("bp_one_handshake", hs1, hs_snap + 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_no_extra_result", ov, 1'b0);
        end
        check("bp_handshake_total", hs1, hs_snap + 1);

        // Reset during CALC discards the operation
        hs_snap = hs1;
        send(32'd1000, 32'd3);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check("abort_out_valid_calc", ov, 1'b0);
        end
        arst = 1'b1;
        sb.delete();
        #1;
        check("arst_out_valid", ov, 1'b0);
        check("arst_in_ready", rdy, 1'b1);
        check("arst_quotient", quo, 32'd0);
        check("arst_remainder", rmd, 32'd0);
        check("arst_div_by_zero", dz, 1'b0);
        @(posedge clk);
        #1;
        arst     = 1'b0;
        dividend = 32'd9;
        divisor  = 32'd4;
        in_valid = 1'b1;
        check("post_rst_in_ready", rdy, 1'b1);
        @(posedge clk);
        sb.push_back(model(32'd9, 32'd4));
        #1;
        in_valid = 1'b0;
        check("post_rst_accepted", rdy, 1'b0);
        wait_result("post_rst_latency", 33);
        consume("post_rst_9_4");
        check("abort_no_result", hs1, hs_snap + 1);

        // Two bits per cycle: directed plus randomized back-to-back
        sel = 1'b1;
        run_op("b2_100_7", 32'd100, 32'd7, 17);
        run_op("b2_5_0", 32'd5, 32'd0, 1);
        run_op("b2_8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 17);
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 4 == 0) rb = rb | 32'h8000_0000;
            if (rb == 32'd0) rb = 32'd1;
            run_op("b2_rand", ra, rb, 17);
        end
        check("b2_handshakes", hs2, 27);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
